viterbi_traceback: RTL and testbench
====================================

# viterbi_traceback

Survivor-memory and traceback stage of the 4-state (K=3, rate-1/2) hard-decision Viterbi decoder. It sits directly downstream of the four ACS units. Each trellis step, it captures the selected predecessor address and path metric from every state. At frame end it traces back from the minimum-metric state and streams the decoded bits out in forward (time) order over a valid/ready handshake.

## Interface
- FRAME_MAX, default 32: maximum trellis steps per frame (power of 2, at least 2); sets the survivor-memory depth.
- PM_W, default 7: path-metric width; must match the ACS PMout width.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- in_valid  in  1  surv_in/pm_in/in_last valid this cycle.
- in_ready  out  1  block accepts a step column.
- in_last  in  1  this column is the final step of the frame.
- surv_in  in  8  predecessor address per state; bits [2i+1:2i] = addr_out of the ACS for state i.
- pm_in  in  4*PM_W  path metric per state; bits [PM_W*(i+1)-1:PM_W*i] = PMout of state i.
- out_valid  out  1  out_bit valid.
- out_ready  in  1  downstream accepts out_bit.
- out_bit  out  1  decoded bit.
- out_last  out  1  marks the final decoded bit of the frame.
- frame_err  out  1  one-cycle pulse: frame truncated at FRAME_MAX.
- busy  out  1  high in TRACE and OUT.

## Operation
- FSM states: FILL, TRACE, OUT. The reset state is FILL.
- **FILL**
  - in_ready=1.
  - Each accepted beat writes surv_in to survivor column wr_cnt, then wr_cnt increments.
  - On an accepted beat with in_last=1, or on the beat with wr_cnt==FRAME_MAX-1:
    - latch N = wr_cnt+1;
    - latch best = the state index with the minimum unsigned pm_in; ties go to the lowest index;
    - go to TRACE.
  - If truncation occurs at FRAME_MAX without in_last, frame_err pulses on the cycle TRACE is entered.
- **Best-state selection** uses pm_in of the final beat only. Earlier pm_in values are ignored.
- **TRACE**
  - in_ready=0.
  - cur starts at best; column index k runs from N-1 down to 0, one column per cycle.
  - Each cycle: bitbuf[k] = cur[1], then cur = surv[k][2*cur+1:2*cur].
  - After column 0 is processed, go to OUT.
- **OUT**
  - in_ready=0.
  - Emit bitbuf[0..N-1] in order. out_bit = bitbuf[rd_cnt]; out_last = (rd_cnt==N-1).
  - rd_cnt advances only on out_valid && out_ready.
  - After the handshake with out_last=1: return to FILL and clear wr_cnt and rd_cnt.
- **Width rules**
  - wr_cnt, rd_cnt and the trace index are clog2(FRAME_MAX) bits. N is clog2(FRAME_MAX)+1 bits.
  - The PM comparison is unsigned at PM_W bits. No normalization is done here.
- in_valid is ignored when in_ready=0. pm_in/surv_in/in_last are don't-care when in_valid=0.
- Reset at any point, including mid-TRACE or mid-OUT:
  - go to FILL; clear all counters; any partial frame is discarded;
  - survivor and bit-buffer contents need not be cleared.

## Timing
- **Reset values:** in_ready=0 while rst_n=0, and 1 from the first cycle after release. out_valid=0, out_bit=0, out_last=0, frame_err=0, busy=0.
- **Latency:** final beat accepted at cycle T → TRACE occupies T+1..T+N → out_valid first high at T+N+1.
- Under continuous out_ready, the last bit is at T+2N and in_ready=1 at T+2N+1.
- out_valid, out_bit and out_last are registered. They hold stable while out_valid && !out_ready.
- out_valid is never dropped before its handshake.
- busy=1 exactly while the FSM is in TRACE or OUT.
- No input column is accepted during TRACE/OUT. There is no overlap between frames.

## Test plan
- **All-zero frame:** 8 beats, surv_in=8'h00, pm_in state0=0 and others=5, in_last on beat 8 at cycle T → 8 zero bits; out_valid first high at T+9; out_last on the 8th bit; in_ready back to 1 at T+17.
- **Known path:** 4 beats with surv_in state fields {s2=00}, {s1=10}, {s2=01}, {s3=10}; final pm_in minimum at state 3 → output 1,0,1,1 with out_last on the 4th bit.
- **Tie and N=1:** single beat with in_last=1, all pm_in=3 → best=0; one bit 0, emitted with out_last=1 at T+2.
- **Overflow:** 32 beats with in_last=0 → frame_err pulses at T+1; exactly 32 bits are output; the 33rd input is accepted only after the final output handshake.
- **Backpressure:** toggle out_ready randomly during OUT → each bit is held stable until its handshake; the sequence is identical to the no-stall run.
- **Reset mid-TRACE:** rst_n low for 1 cycle during TRACE → next cycle FILL, in_ready=1, out_valid=0; a following 8-beat frame decodes correctly.

Source files
------------

// File: rtl/viterbi_traceback.sv
// Purpose  : survivor memory + traceback for the 4-state (K=3, r=1/2) hard-decision Viterbi decoder.
// Latency  : final column accepted at T -> traceback T+1..T+N -> first decoded bit valid at T+N+1.
// Backpres.: in_ready low during TRACE/OUT (one frame in flight); out_* held stable until out_ready.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   in_valid/in_ready/in_last     step-column handshake, in_last marks the frame's final column
//   surv_in[2i+1:2i]              ACS predecessor address for state i
//   pm_in[PM_W*(i+1)-1:PM_W*i]    ACS path metric for state i
//   out_valid/out_ready           decoded-bit handshake; out_bit data, out_last final bit of frame
//   frame_err                     one-cycle pulse: frame cut at FRAME_MAX without in_last
//   busy                          high while tracing back or emitting bits
module viterbi_traceback #(
    parameter int FRAME_MAX = 32,
    parameter int PM_W      = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_last,
    input  logic [7:0]          surv_in,
    input  logic [4*PM_W-1:0]   pm_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic                out_last,
    output logic                frame_err,
    output logic                busy
);

    localparam int AW = (FRAME_MAX > 1) ? $clog2(FRAME_MAX) : 1;

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_TRACE = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]           state;
    logic [AW-1:0]        wr_cnt;
    logic [AW-1:0]        rd_cnt;
    logic [AW-1:0]        k_idx;
    logic [AW:0]          n_len;
    logic [1:0]           cur;

    logic [7:0]           surv_mem [FRAME_MAX];
    logic [FRAME_MAX-1:0] bit_buf;

    logic                 accept;
    logic                 frame_end;
    logic [1:0]           best_idx;
    logic [PM_W-1:0]      best_pm;
    logic [7:0]           surv_col;
    logic [1:0]           pred;
    logic [AW-1:0]        rd_nxt;
    logic [AW:0]          n_last;

    assign in_ready  = rst_n && (state == S_FILL);
    assign busy      = (state == S_TRACE) || (state == S_OUT);
    assign accept    = in_valid && in_ready;
    // Truncation at the last survivor column ends the frame even without in_last.
    assign frame_end = accept && (in_last || (wr_cnt == AW'(FRAME_MAX - 1)));

    // Minimum-metric state of the current column; strict '<' keeps the lowest index on ties.
    always_comb begin
        best_pm  = pm_in[PM_W-1:0];
        best_idx = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (pm_in[PM_W*i +: PM_W] < best_pm) begin
                best_pm  = pm_in[PM_W*i +: PM_W];
                best_idx = 2'(i);
            end
        end
    end

    assign surv_col = surv_mem[k_idx];
    assign pred     = surv_col[{cur, 1'b0} +: 2];
    assign rd_nxt   = rd_cnt + AW'(1);
    assign n_last   = n_len - (AW+1)'(1);

    // Survivor and bit-buffer storage: no reset needed, every location is written before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            surv_mem[wr_cnt] <= surv_in;
        end
        if (state == S_TRACE) begin
            bit_buf[k_idx] <= cur[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            k_idx     <= '0;
            n_len     <= '0;
            cur       <= 2'd0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        wr_cnt <= wr_cnt + AW'(1);
                        if (frame_end) begin
                            n_len     <= {1'b0, wr_cnt} + (AW+1)'(1);
                            k_idx     <= wr_cnt;
                            cur       <= best_idx;
                            frame_err <= !in_last;
                            state     <= S_TRACE;
                        end
                    end
                end
                S_TRACE: begin
                    cur <= pred;
                    if (k_idx == '0) begin
                        // bit_buf[0] is being written this same cycle, so forward it directly.
                        state     <= S_OUT;
                        rd_cnt    <= '0;
                        out_valid <= 1'b1;
                        out_bit   <= cur[1];
                        out_last  <= (n_len == (AW+1)'(1));
                    end else begin
                        k_idx <= k_idx - AW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= S_FILL;
                            out_valid <= 1'b0;
                            out_bit   <= 1'b0;
                            out_last  <= 1'b0;
                            wr_cnt    <= '0;
                            rd_cnt    <= '0;
                        end else begin
                            rd_cnt   <= rd_nxt;
                            out_bit  <= bit_buf[rd_nxt];
                            out_last <= ({1'b0, rd_nxt} == n_last);
                        end
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Purpose  : self-checking bench for viterbi_traceback (scoreboard of expected decoded bits).
// Latency  : checks first-valid and in_ready-return cycles against the frame length.
// Backpres.: out_ready driven random in one run; held outputs checked for stability.
module tb_viterbi_traceback;

    localparam int PM_W = 7;
    localparam int FMAX = 32;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [7:0]        surv_in;
    logic [4*PM_W-1:0] pm_in;
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic              out_last;
    logic              frame_err;
    logic              busy;

    viterbi_traceback #(.FRAME_MAX(FMAX), .PM_W(PM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .surv_in   (surv_in),
        .pm_in     (pm_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_last  (out_last),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_acc = 0;
    bit         bp_mode = 1'b0;
    logic [1:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4*PM_W-1:0] pm4(input int a, input int b, input int c, input int d);
        return {PM_W'(d), PM_W'(c), PM_W'(b), PM_W'(a)};
    endfunction

    // Expected bits, LSB first = first in output order; out_last on the n-th.
    task automatic push_bits(input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({bits[i], i == n - 1});
    endtask

    // Presents a column with in_valid held high until the DUT takes it.
    task automatic send_beat(input logic [7:0] s, input logic [4*PM_W-1:0] pm, input logic last);
        int g;
        in_valid = 1'b1; surv_in = s; pm_in = pm; in_last = last;
        g = 0;
        while (!in_ready && g < 300) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 300) begin
            checks++; errors++;
            $display("FAIL in_ready_wait: got timeout expected in_ready within 300 cycles");
        end
        @(posedge clk); #1;
        last_acc = cyc;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // e = edge count right after the final column was accepted.
    task automatic check_frame_timing(input int n, input int e);
        int c;
        @(negedge clk);
        check("frame_err_clear", frame_err, 0);
        check("busy_trace", busy, 1);
        c = 0;
        while (!out_valid && c < 200) begin @(negedge clk); c++; end
        check("first_valid_cycle", cyc - e, n);
        c = 0;
        while (!in_ready && c < 400) begin @(negedge clk); c++; end
        check("in_ready_return", cyc - e, 2 * n);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || !in_ready) && c < 1000) begin @(negedge clk); c++; end
        check("drain", exp_q.size(), 0);
    endtask

    // out_ready: always high, or random while bp_mode is set.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expected bits on each handshake, checks stalled outputs hold.
    initial begin
        logic [1:0] e;
        bit prev_hold;
        logic prev_bit, prev_last;
        prev_hold = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_hold) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_bit", out_bit, prev_bit);
                    check("hold_last", out_last, prev_last);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got bit %0d with empty scoreboard", out_bit);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_bit", out_bit, e[1]);
                        check("out_last", out_last, e[0]);
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_bit  = out_bit;
                prev_last = out_last;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        int e;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; surv_in = 8'h00; pm_in = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_bit", out_bit, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // All-zero frame, 8 beats.
        push_bits(64'h0, 8);
        for (int i = 0; i < 8; i++) send_beat(8'h00, pm4(0, 5, 5, 5), i == 7);
        check_frame_timing(8, last_acc);
        wait_idle();

        // Known path: decodes to 1,0,1,1; earlier metrics favour state 0 and must be ignored.
        push_bits(64'hD, 4);
        send_beat(8'h00, pm4(0, 9, 9, 9), 1'b0);
        send_beat(8'h08, pm4(0, 9, 9, 9), 1'b0);
        send_beat(8'h10, pm4(0, 9, 9, 9), 1'b0);
        send_beat(8'h80, pm4(9, 8, 7, 2), 1'b1);
        check_frame_timing(4, last_acc);
        wait_idle();

        // N=1 with all-equal metrics: best state 0 -> single 0 bit.
        push_bits(64'h0, 1);
        send_beat(8'hFF, pm4(3, 3, 3, 3), 1'b1);
        check_frame_timing(1, last_acc);
        wait_idle();

        // Overflow: 32 beats without in_last; all predecessors 3, best 2 -> all ones.
        push_bits(64'hFFFF_FFFF, 32);
        push_bits(64'h1, 1);
        for (int i = 0; i < 32; i++) send_beat(8'hFF, pm4(5, 5, 1, 5), 1'b0);
        e = last_acc;
        fork
            begin
                @(negedge clk);
                check("ovf_frame_err_pulse", frame_err, 1);
                @(negedge clk);
                check("ovf_frame_err_end", frame_err, 0);
            end
            send_beat(8'h00, pm4(4, 4, 0, 4), 1'b1);
        join
        check("ovf_next_accept_cycle", last_acc - e, 65);
        wait_idle();

        // Backpressure: known path again with random out_ready.
        bp_mode = 1'b1;
        push_bits(64'hD, 4);
        send_beat(8'h00, pm4(0, 9, 9, 9), 1'b0);
        send_beat(8'h08, pm4(0, 9, 9, 9), 1'b0);
        send_beat(8'h10, pm4(0, 9, 9, 9), 1'b0);
        send_beat(8'h80, pm4(9, 8, 7, 2), 1'b1);
        wait_idle();
        bp_mode = 1'b0;
        @(posedge clk); #1;

        // Reset mid-TRACE: partial frame discarded, nothing pushed for it.
        for (int i = 0; i < 8; i++) send_beat(8'h00, pm4(0, 5, 5, 5), i == 7);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        @(posedge clk); #1;

        // Predecessor of state i is 3-i, best state 1 -> 1,0,1,0,1,0,1,0.
        push_bits(64'h55, 8);
        for (int i = 0; i < 8; i++) send_beat(8'h1B, pm4(5, 0, 5, 5), i == 7);
        check_frame_timing(8, last_acc);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
